// File: rtl/nv_lsd_blk_norm_ctrl.sv
// Block-floating-point normalization controller: finds the common left shift
// (minimum redundant-sign-bit count, clamped) over a block of signed elements.

module nv_dw_lsd #(
  parameter int A_WIDTH = 16,
  parameter int ENC_W   = $clog2(A_WIDTH)
) (
  input  logic [A_WIDTH-1:0] a,
  output logic [ENC_W-1:0]   enc
);

  // The highest bit that differs from the sign bit bounds the redundant-sign
  // run. Later (higher) iterations override earlier ones.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    enc = ENC_W'(A_WIDTH - 1);
    for (int i = 0; i <= A_WIDTH - 2; i++) begin
      if (a[i] != a[A_WIDTH-1]) begin
        enc = ENC_W'(A_WIDTH - 2 - i);
      end
    end
  end

endmodule

module nv_lsd_blk_norm_ctrl #(
  parameter int DW        = 16,
  parameter int BLK_MAX   = 16,
  parameter int MAX_SHIFT = 15,   // must not exceed DW-1
  localparam int ENC_W    = $clog2(DW),
  localparam int CNT_W    = $clog2(BLK_MAX + 1)
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic             in_pvld,
  output logic             in_prdy,
  input  logic [DW-1:0]    in_pd,
  input  logic             in_last,
  output logic             out_pvld,
  input  logic             out_prdy,
  output logic [ENC_W-1:0] out_shift,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_forced
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  localparam logic [ENC_W-1:0] MAX_SHIFT_C = ENC_W'(MAX_SHIFT);
  localparam logic [CNT_W-1:0] BLK_MAX_C   = CNT_W'(BLK_MAX);

  logic [1:0]       state;
  logic [ENC_W-1:0] min_enc;
  logic [CNT_W-1:0] count;

  logic [ENC_W-1:0] enc;
  logic             accept;
  logic [ENC_W-1:0] blk_min;
  logic [CNT_W-1:0] cnt_next;
  logic             close_blk;
  logic [ENC_W-1:0] shift_clamped;

  nv_dw_lsd #(
    .A_WIDTH (DW),
    .ENC_W   (ENC_W)
  ) u_lsd (
    .a   (in_pd),
    .enc (enc)
  );

  assign in_prdy = !nvdla_core_rst && (state != ST_OUT);
  assign accept  = in_pvld && in_prdy;

  // Running minimum and count as they would be after the current element,
  // so the closing accept can load results that include it.
  always_comb begin
    blk_min       = enc;
    cnt_next      = CNT_W'(1);
    if (state == ST_ACC) begin
      if (min_enc < enc) begin
        blk_min = min_enc;
      end
      cnt_next = count + 1'b1;
    end
    close_blk     = in_last || (cnt_next == BLK_MAX_C);
    shift_clamped = (blk_min > MAX_SHIFT_C) ? MAX_SHIFT_C : blk_min;
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state      <= ST_IDLE;
      out_pvld   <= 1'b0;
      out_shift  <= '0;
      out_cnt    <= '0;
      out_forced <= 1'b0;
      min_enc    <= '1;
      count      <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_ACC: begin
          if (accept) begin
            min_enc <= blk_min;
            count   <= cnt_next;
            if (close_blk) begin
              state      <= ST_OUT;
              out_pvld   <= 1'b1;
              out_shift  <= shift_clamped;
              out_cnt    <= cnt_next;
              out_forced <= !in_last;
            end else begin
              state <= ST_ACC;
            end
          end
        end
        ST_OUT: begin
          if (out_prdy) begin
            state    <= ST_IDLE;
            out_pvld <= 1'b0;
            min_enc  <= '1;
            count    <= '0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          out_pvld <= 1'b0;
          min_enc  <= '1;
          count    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nv_lsd_blk_norm_ctrl.sv
// Randomized and directed bench for nv_lsd_blk_norm_ctrl; two instances
// (MAX_SHIFT 15 and 8) share stimulus and are checked against a block model.

module tb_nv_lsd_blk_norm_ctrl;

  localparam int DW      = 16;
  localparam int BLK_MAX = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_pvld;
  logic [DW-1:0] in_pd;
  logic          in_last;
  logic          out_prdy;

  logic          in_prdy_a,   in_prdy_b;
  logic          out_pvld_a,  out_pvld_b;
  logic [3:0]    out_shift_a, out_shift_b;
  logic [4:0]    out_cnt_a,   out_cnt_b;
  logic          out_forced_a, out_forced_b;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: elements of the open block, plus the pending result.
  int queue_enc[$];
  bit pend;
  int exp_shift15, exp_shift8, exp_cnt;
  bit exp_forced;

  always #5 clk = ~clk;

  nv_lsd_blk_norm_ctrl #(.DW(DW), .BLK_MAX(BLK_MAX), .MAX_SHIFT(15)) u_dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .in_pvld        (in_pvld),
    .in_prdy        (in_prdy_a),
    .in_pd          (in_pd),
    .in_last        (in_last),
    .out_pvld       (out_pvld_a),
    .out_prdy       (out_prdy),
    .out_shift      (out_shift_a),
    .out_cnt        (out_cnt_a),
    .out_forced     (out_forced_a)
  );

  nv_lsd_blk_norm_ctrl #(.DW(DW), .BLK_MAX(BLK_MAX), .MAX_SHIFT(8)) u_dut_c8 (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .in_pvld        (in_pvld),
    .in_prdy        (in_prdy_b),
    .in_pd          (in_pd),
    .in_last        (in_last),
    .out_pvld       (out_pvld_b),
    .out_prdy       (out_prdy),
    .out_shift      (out_shift_b),
    .out_cnt        (out_cnt_b),
    .out_forced     (out_forced_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Redundant sign bits: DW-1 minus the magnitude bits needed after folding
  // negatives onto their one's complement.
  function automatic int ref_enc(input logic [DW-1:0] v);
    int u = int'(v);
    int n = 0;
    if (u >= (1 << (DW - 1))) u = (1 << DW) - 1 - u;
    while (u > 0) begin
      u = u / 2;
      n++;
    end
    return DW - 1 - n;
  endfunction

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // One clock: compare at the falling edge, advance the model, then wait for
  // the rising edge. Returns whether the current element was accepted.
  task automatic step(output bit accepted);
    bit exp_prdy;
    int m;
    @(negedge clk);
    exp_prdy = !rst && !pend;
    check("in_prdy",      in_prdy_a,  exp_prdy);
    check("in_prdy_c8",   in_prdy_b,  exp_prdy);
    check("out_pvld",     out_pvld_a, pend);
    check("out_pvld_c8",  out_pvld_b, pend);
    if (pend) begin
      check("out_shift",    out_shift_a,  exp_shift15);
      check("out_shift_c8", out_shift_b,  exp_shift8);
      check("out_cnt",      out_cnt_a,    exp_cnt);
      check("out_cnt_c8",   out_cnt_b,    exp_cnt);
      check("out_forced",   out_forced_a, exp_forced);
    end
    accepted = 1'b0;
    if (rst) begin
      pend = 1'b0;
      queue_enc.delete();
    end else if (pend) begin
      if (out_prdy) pend = 1'b0;
    end else if (in_pvld) begin
      accepted = 1'b1;
      queue_enc.push_back(ref_enc(in_pd));
      if (in_last || queue_enc.size() == BLK_MAX) begin
        m = DW;
        foreach (queue_enc[i]) m = min_int(m, queue_enc[i]);
        exp_shift15 = min_int(m, 15);
        exp_shift8  = min_int(m, 8);
        exp_cnt     = queue_enc.size();
        exp_forced  = !in_last;
        pend        = 1'b1;
        queue_enc.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    in_pvld = 1'b0;
    for (int i = 0; i < n; i++) step(acc);
  endtask

  task automatic push(input logic [DW-1:0] v, input bit last);
    bit acc = 1'b0;
    int waited = 0;
    in_pvld = 1'b1;
    in_pd   = v;
    in_last = last;
    while (!acc && waited < 50) begin
      step(acc);
      waited++;
    end
    if (!acc) check("push_timeout", 32'd0, 32'd1);
    in_pvld = 1'b0;
    in_pd   = $urandom;
    in_last = $urandom_range(0, 1);
  endtask

  initial begin
    bit acc;
    logic [DW-1:0] v;
    pend     = 1'b0;
    rst      = 1'b1;
    in_pvld  = 1'b0;
    in_pd    = '0;
    in_last  = 1'b0;
    out_prdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_shift",  out_shift_a,  4'd0);
    check("rst_cnt",    out_cnt_a,    5'd0);
    check("rst_forced", out_forced_a, 1'b0);
    step(acc);
    rst = 1'b0;
    idle(2);

    // Mixed block: min enc is 3 (0x0F00).
    push(16'h0F00, 1'b0);
    push(16'hFFF0, 1'b0);
    push(16'h0001, 1'b1);
    idle(2);

    // Zero element clamps to MAX_SHIFT on each instance.
    push(16'h0000, 1'b1);
    idle(2);

    // Forced close at BLK_MAX, then the 17th element waits and starts a new block.
    for (int i = 0; i < BLK_MAX; i++) push(16'h0001, 1'b0);
    push(16'h0001, 1'b1);
    idle(2);

    // Back-pressure with a zero-shift block.
    out_prdy = 1'b0;
    push(16'h1234, 1'b0);
    push(16'h8000, 1'b1);
    in_pvld = 1'b1;
    in_pd   = 16'h0100;
    in_last = 1'b1;
    for (int i = 0; i < 5; i++) step(acc);
    out_prdy = 1'b1;
    push(16'h0100, 1'b1);
    idle(2);

    // Reset mid-block discards it.
    push(16'h0003, 1'b0);
    push(16'h0007, 1'b0);
    rst = 1'b1;
    step(acc);
    rst = 1'b0;
    push(16'h00FF, 1'b1);
    idle(2);

    // Back-to-back single-element blocks.
    in_pvld = 1'b1;
    in_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_pd = $urandom;
      step(acc);
    end
    idle(2);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      v = DW'($urandom) >> $urandom_range(0, DW);
      if ($urandom_range(0, 1) == 1) v = ~v;
      in_pd    = v;
      in_pvld  = ($urandom_range(0, 3) != 0);
      in_last  = ($urandom_range(0, 5) == 0);
      out_prdy = ($urandom_range(0, 2) != 0);
      rst      = ($urandom_range(0, 199) == 0);
      step(acc);
    end
    rst      = 1'b0;
    out_prdy = 1'b1;
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
